// File: rtl/ook_beacon_tx.sv
// Optical OOK beacon transmitter: preamble, sync byte, payload and optional CRC-8, Manchester-coded on led_out.
// Define TX_CRC8_EN to append a CRC-8 (poly 0x07, init 0) byte after the payload.
module ook_beacon_tx #(
   parameter int unsigned CLK_DIV      = 50,
   parameter int unsigned PREAMBLE_LEN = 16,
   parameter logic [7:0]  SYNC_BYTE    = 8'hD5,
   parameter int unsigned GAP_CHIPS    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] len,
   input  logic [7:0] din,
   input  logic       den,
   output logic       din_rdy,
   output logic       led_out,
   output logic       bout,
   output logic       ben,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int unsigned CW      = $clog2(CLK_DIV);
   localparam int unsigned PW      = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
   localparam int unsigned GAP_CYC = GAP_CHIPS * CLK_DIV;
   localparam int unsigned GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_LEN - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

`ifdef TX_CRC8_EN
   typedef enum logic [2:0] {S_IDLE, S_PRE, S_SYNC, S_DATA, S_CRC, S_GAP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_PRE, S_SYNC, S_DATA, S_GAP} state_t;
`endif

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic            half_q;
   logic [PW-1:0]   pre_cnt_q;
   logic [2:0]      bit_idx_q;
   logic [7:0]      sh_q;
   logic [7:0]      hold_q;
   logic            hold_vld_q;
   logic [7:0]      len_q;
   logic [7:0]      sent_q;
   logic [7:0]      acc_q;
   logic [GW-1:0]   gap_cnt_q;
`ifdef TX_CRC8_EN
   logic [7:0]      crc_q;
`endif

   logic       in_bits, bit_end, byte_end, more_data, hs;
   logic       frame_start, new_bit, new_val, sh_load, sh_shift, hold_take, to_gap, underrun;
   logic [7:0] sh_val;

`ifdef TX_CRC8_EN
   function automatic logic [7:0] crc8_next(input logic [7:0] c);
      logic [7:0] r;
      r = c;
      for (int unsigned i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
      return r;
   endfunction
`endif

   assign busy      = (state_q != S_IDLE);
   assign in_bits   = busy && (state_q != S_GAP);
   assign done      = (state_q == S_GAP) && (gap_cnt_q == GAP_LAST);
   assign din_rdy   = ((state_q == S_PRE) || (state_q == S_SYNC) || (state_q == S_DATA))
                      && !hold_vld_q && (acc_q != len_q);
   assign hs        = den && din_rdy;
   assign bit_end   = in_bits && half_q && (cnt_q == CNT_LAST);
   assign byte_end  = bit_end && (bit_idx_q == 3'd7);
   assign more_data = (sent_q != len_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Every bit boundary decides the next bit, so led_out/bout/ben all load on the same edge.
   always_comb begin
      state_d     = state_q;
      frame_start = 1'b0;
      new_bit     = 1'b0;
      new_val     = 1'b0;
      sh_load     = 1'b0;
      sh_val      = '0;
      sh_shift    = 1'b0;
      hold_take   = 1'b0;
      to_gap      = 1'b0;
      underrun    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start && (len != '0)) begin
               state_d     = S_PRE;
               frame_start = 1'b1;
               new_bit     = 1'b1;
               new_val     = 1'b1;
            end
         end
         S_PRE: begin
            if (bit_end) begin
               new_bit = 1'b1;
               if (pre_cnt_q == PRE_LAST) begin
                  state_d = S_SYNC;
                  sh_load = 1'b1;
                  sh_val  = SYNC_BYTE;
                  new_val = SYNC_BYTE[7];
               end else begin
                  new_val = pre_cnt_q[0];
               end
            end
         end
`ifdef TX_CRC8_EN
         S_SYNC, S_DATA, S_CRC: begin
`else
         S_SYNC, S_DATA: begin
`endif
            if (bit_end) begin
               if (!byte_end) begin
                  new_bit  = 1'b1;
                  new_val  = sh_q[6];
                  sh_shift = 1'b1;
               end else if (more_data) begin
                  if (hold_vld_q) begin
                     state_d   = S_DATA;
                     hold_take = 1'b1;
                     sh_load   = 1'b1;
                     sh_val    = hold_q;
                     new_bit   = 1'b1;
                     new_val   = hold_q[7];
                  end else begin
                     underrun = 1'b1;
                     to_gap   = 1'b1;
                  end
               end else begin
`ifdef TX_CRC8_EN
                  if (state_q == S_DATA) begin
                     state_d = S_CRC;
                     sh_load = 1'b1;
                     sh_val  = crc_q;
                     new_bit = 1'b1;
                     new_val = crc_q[7];
                  end else begin
                     to_gap = 1'b1;
                  end
`else
                  to_gap = 1'b1;
`endif
               end
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (to_gap) state_d = S_GAP;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         half_q     <= 1'b0;
         pre_cnt_q  <= '0;
         bit_idx_q  <= '0;
         sh_q       <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         len_q      <= '0;
         sent_q     <= '0;
         acc_q      <= '0;
         gap_cnt_q  <= '0;
         led_out    <= 1'b0;
         bout       <= 1'b0;
         ben        <= 1'b0;
         err        <= 1'b0;
`ifdef TX_CRC8_EN
         crc_q      <= '0;
`endif
      end else begin
         ben <= new_bit;
         err <= underrun;
         if (new_bit) begin
            cnt_q   <= '0;
            half_q  <= 1'b0;
            led_out <= new_val;
            bout    <= new_val;
         end else if (in_bits) begin
            if (cnt_q == CNT_LAST) begin
               cnt_q   <= '0;
               half_q  <= ~half_q;
               led_out <= ~led_out;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
         if (to_gap) begin
            led_out   <= 1'b0;
            bout      <= 1'b0;
            gap_cnt_q <= '0;
         end else if (state_q == S_GAP) begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
         end

         if (frame_start)                          pre_cnt_q <= '0;
         else if (new_bit && (state_q == S_PRE))   pre_cnt_q <= pre_cnt_q + 1'b1;

         if (sh_load) begin
            sh_q      <= sh_val;
            bit_idx_q <= '0;
         end else if (sh_shift) begin
            sh_q      <= sh_q << 1;
            bit_idx_q <= bit_idx_q + 1'b1;
         end

         if (frame_start) begin
            len_q      <= len;
            sent_q     <= '0;
            acc_q      <= '0;
            hold_vld_q <= 1'b0;
`ifdef TX_CRC8_EN
            crc_q      <= '0;
`endif
         end else begin
            if (hs) begin
               hold_q <= din;
               acc_q  <= acc_q + 8'd1;
            end
            if (hs)             hold_vld_q <= 1'b1;
            else if (hold_take) hold_vld_q <= 1'b0;
            if (hold_take) begin
               sent_q <= sent_q + 8'd1;
`ifdef TX_CRC8_EN
               crc_q  <= crc8_next(crc_q ^ hold_q);
`endif
            end
         end
      end
   end

endmodule
